puf_sequencer: RTL and testbench
================================

Name: puf_sequencer

Overview:
- Parametrised controller for a bank of NUM_RINGS bistable-ring PUFs of different lengths; the ring instances sit outside this block.
- Selects one ring, applies a challenge and pulses that ring's reset. After a settle time it samples the ring output through a synchroniser.
- Repeats VOTES times per bit and majority-votes the samples. Builds a RESP_BITS-bit response, advancing the challenge with an LFSR between bits.
- Unselected rings are always held in reset.

Parameters:
- NUM_RINGS, 3: number of attached rings; ring_sel index 0 is the shortest ring.
- SEL_W, 2: width of ring_sel; must be ≥ clog2(NUM_RINGS).
- CHAL_W, 128: challenge width, shared by all rings; shorter rings use the LSBs.
- RESP_BITS, 8: response bits per request.
- VOTES, 3: samples per bit; must be odd.
- RST_CYCLES, 4: cycles the selected ring is held in reset before each sample.
- SETTLE_CYCLES, 16: cycles after reset release before sampling; must be ≥ 2.
- TAPS, bits {127,125,100,98} set: Fibonacci LFSR tap mask.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only in IDLE
- abort  in  1  synchronous cancel; return to IDLE
- ring_sel  in  SEL_W  ring select, captured at start
- challenge  in  CHAL_W  seed challenge, captured at start
- ring_out  in  NUM_RINGS  asynchronous ring outputs
- ring_reset  out  NUM_RINGS  per-ring reset, active-high
- chal_out  out  CHAL_W  challenge driven to the rings
- busy  out  1  high in any state except IDLE
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp  out  RESP_BITS  majority-voted response
- resp_unstable  out  RESP_BITS  per-bit non-unanimous flag (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE; ring_reset all ones; chal_out, resp, resp_unstable, busy, resp_valid all 0.
  - Counters and synchroniser cleared.
- Ring select clamping: ring_sel ≥ NUM_RINGS is clamped to NUM_RINGS-1, i.e. the longest ring.
- Synchroniser: ring_out passes through a free-running 2-flop synchroniser. Only the selected ring's synchronised bit is used.
- ring_reset:
  - bit sel is low only in SETTLE and SAMPLE;
  - all other bits are high in every state;
  - in IDLE and DONE all bits are high.
- IDLE:
  - start=1 → capture sel and challenge (chal_out=challenge), clear the bit, vote and ones counters, go to RESET.
  - start while not in IDLE is ignored.
- RESET: RST_CYCLES cycles, then SETTLE.
- SETTLE: SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (1 cycle): add the synchronised bit to the ones count, then:
  - If vote_idx < VOTES-1: increment vote_idx and go to RESET.
  - Else:
    - bit = (ones > VOTES/2); shift it into resp LSB, so the first bit ends at the MSB;
    - chal_out ← {chal_out[CHAL_W-2:0], ^(chal_out & TAPS)};
    - clear the vote and ones counters;
    - if bit_idx < RESP_BITS-1, increment bit_idx and go to RESET; else go to DONE.
- DONE:
  - resp_valid=1, resp stable.
  - When resp_valid && resp_ready, go to IDLE next cycle and drop resp_valid.
  - resp keeps its value in IDLE until the next start.
- Latency: with start sampled at edge k, resp_valid rises at edge k + RESP_BITS·VOTES·(RST_CYCLES+SETTLE_CYCLES+1).
- Challenge timing: chal_out is constant for all votes of one bit. It changes only at the final SAMPLE of each bit and holds its last value in IDLE.
- abort:
  - from any non-IDLE state → IDLE next cycle; all rings held in reset;
  - resp_valid is never asserted for the aborted request; resp is left partial;
  - abort together with start in IDLE: abort wins and the request is not accepted.
- resp_ready outside DONE is ignored.
- Mid-operation reset_n: immediate return to the reset state above; no response is produced.

Optional Feature:
- Macro: PUF_STABILITY_EN.
- Defined:
  - per bit, resp_unstable gets 1 when ones ∉ {0, VOTES}; it is shifted in parallel with resp;
  - also provides a 16-bit saturating unstable-bit counter. It is cleared by reset_n, increments on each unstable bit and is readable on a port unstable_cnt.
- Undefined: resp_unstable is tied to 0, the unstable_cnt port is absent and no counter logic is built.

Test Plan:
- Bench parameters: RESP_BITS=4, VOTES=3, RST=2, SETTLE=3, NUM_RINGS=3.
- Ring model outputs challenge[0] XOR ring index, sel=1, start with challenge=1 → resp_valid exactly 72 cycles after start. resp matches the LFSR-predicted sequence. ring_reset[0] and ring_reset[2] are never 0.
- ring_sel=3 → ring 2 used (ring_reset[2] toggles, others stay high); response matches the ring-2 model.
- Ring 0 model outputs 1,0,1 across the three votes of each bit → resp=4'b1111. With PUF_STABILITY_EN: resp_unstable=4'b1111 and unstable_cnt=4.
- abort asserted in the SETTLE of bit 2 → IDLE next cycle, ring_reset=3'b111, resp_valid stays 0. A following start completes normally in 72 cycles.
- resp_ready held low for 10 cycles in DONE → resp_valid and resp stable for 10 cycles; start pulses during DONE ignored. Accept → IDLE, busy=0.
- reset_n pulled low mid-SAMPLE → outputs immediately at reset values, ring_reset=3'b111.

Source files
------------

// File: rtl/puf_sequencer_if.sv
// Request/response bundle between a PUF consumer and the puf_sequencer.
// The consumer drives the master side; the sequencer implements the slave side.
interface puf_sequencer_if #(
  parameter int SEL_W     = 2,
  parameter int CHAL_W    = 128,
  parameter int RESP_BITS = 8
);
  logic                 start;
  logic                 abort;
  logic [SEL_W-1:0]     ring_sel;
  logic [CHAL_W-1:0]    challenge;
  logic                 busy;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RESP_BITS-1:0] resp;
  logic [RESP_BITS-1:0] resp_unstable;

  modport master (
    output start, abort, ring_sel, challenge, resp_ready,
    input  busy, resp_valid, resp, resp_unstable
  );

  modport slave (
    input  start, abort, ring_sel, challenge, resp_ready,
    output busy, resp_valid, resp, resp_unstable
  );
endinterface

// File: rtl/puf_sequencer.sv
// Bistable-ring PUF sequencer: per-bit reset/settle/sample with majority vote, LFSR challenge stepping.
// Latency: resp_valid RESP_BITS*VOTES*(RST_CYCLES+SETTLE_CYCLES+1) cycles after start; PUF_STABILITY_EN adds stability flags/counter.
// Backpressure: response held in DONE until resp_ready; start outside IDLE is dropped, abort cancels at any time.
module puf_sequencer #(
  parameter int NUM_RINGS     = 3,
  parameter int SEL_W         = 2,
  parameter int CHAL_W        = 128,
  parameter int RESP_BITS     = 8,
  parameter int VOTES         = 3,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter logic [CHAL_W-1:0] TAPS =
    CHAL_W'({1'b1, 1'b0, 1'b1, 24'b0, 1'b1, 1'b0, 1'b1, 98'b0})
) (
  input  logic                 clk,
  input  logic                 reset_n,
  puf_sequencer_if.slave       req,
  input  logic [NUM_RINGS-1:0] ring_out,
  output logic [NUM_RINGS-1:0] ring_reset,
  output logic [CHAL_W-1:0]    chal_out
`ifdef PUF_STABILITY_EN
  ,
  output logic [15:0]          unstable_cnt
`endif
);

  localparam int CYC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int VOTE_W  = $clog2(VOTES + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  localparam logic [CYC_W-1:0]  RST_LAST    = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST   = VOTE_W'(VOTES - 1);
  localparam logic [VOTE_W-1:0] VOTE_HALF   = VOTE_W'(VOTES / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_BITS - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX     = SEL_W'(NUM_RINGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q;
  logic [VOTE_W-1:0]    vote_q;
  logic [VOTE_W-1:0]    ones_q;
  logic [BIT_W-1:0]     bit_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     sel_clamped;
  logic [CHAL_W-1:0]    chal_q;
  logic [RESP_BITS-1:0] resp_q;
  logic [NUM_RINGS-1:0] sync_q1, sync_q2;
  logic [NUM_RINGS-1:0] sel_onehot;
  logic                 sample_bit;
  logic [VOTE_W-1:0]    ones_nxt;
  logic                 bit_val;
  logic                 feedback;
  logic                 accept;
  logic                 sample_fire;
  logic                 vote_last;
  logic                 bit_last;

  // Ring outputs are fully asynchronous; only the selected lane is ever consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ring_out;
      sync_q2 <= sync_q1;
    end
  end

  always_comb begin
    sel_clamped = (req.ring_sel > SEL_MAX) ? SEL_MAX : req.ring_sel;
    sel_onehot  = NUM_RINGS'(1) << sel_q;
    sample_bit  = |(sync_q2 & sel_onehot);
    ones_nxt    = ones_q + VOTE_W'(sample_bit);
    bit_val     = (ones_nxt > VOTE_HALF);
    feedback    = ^(chal_q & TAPS);
    vote_last   = (vote_q == VOTE_LAST);
    bit_last    = (bit_q == BIT_LAST);
    accept      = (state_q == ST_IDLE) && req.start && !req.abort;
    sample_fire = (state_q == ST_SAMPLE) && !req.abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (req.abort)             state_d = ST_IDLE;
        else if (cyc_q == RST_LAST) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (req.abort)                state_d = ST_IDLE;
        else if (cyc_q == SETTLE_LAST) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (req.abort)                state_d = ST_IDLE;
        else if (vote_last && bit_last) state_d = ST_DONE;
        else                          state_d = ST_RESET;
      end
      ST_DONE: begin
        if (req.abort || req.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change so RESET/SETTLE each count from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
    end else if (state_d != state_q) begin
      cyc_q <= '0;
    end else if ((state_q == ST_RESET) || (state_q == ST_SETTLE)) begin
      cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q  <= '0;
      chal_q <= '0;
      resp_q <= '0;
      vote_q <= '0;
      ones_q <= '0;
      bit_q  <= '0;
    end else if (accept) begin
      sel_q  <= sel_clamped;
      chal_q <= req.challenge;
      vote_q <= '0;
      ones_q <= '0;
      bit_q  <= '0;
    end else if (sample_fire) begin
      if (!vote_last) begin
        vote_q <= vote_q + VOTE_W'(1);
        ones_q <= ones_nxt;
      end else begin
        vote_q <= '0;
        ones_q <= '0;
        // First resolved bit walks up to the MSB as later bits arrive.
        resp_q <= (resp_q << 1) | RESP_BITS'(bit_val);
        chal_q <= (chal_q << 1) | CHAL_W'(feedback);
        if (!bit_last) bit_q <= bit_q + BIT_W'(1);
      end
    end
  end

`ifdef PUF_STABILITY_EN
  logic [RESP_BITS-1:0] unst_q;
  logic [15:0]          unst_cnt_q;
  logic                 bit_unstable;

  always_comb begin
    bit_unstable = (ones_nxt != '0) && (ones_nxt != VOTE_W'(VOTES));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unst_q     <= '0;
      unst_cnt_q <= '0;
    end else if (sample_fire && vote_last) begin
      unst_q <= (unst_q << 1) | RESP_BITS'(bit_unstable);
      if (bit_unstable && (unst_cnt_q != 16'hFFFF)) unst_cnt_q <= unst_cnt_q + 16'd1;
    end
  end

  assign req.resp_unstable = unst_q;
  assign unstable_cnt      = unst_cnt_q;
`else
  assign req.resp_unstable = '0;
`endif

  // Only the selected ring is ever released, and only while it settles and is sampled.
  always_comb begin
    ring_reset = '1;
    if ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE)) ring_reset = ~sel_onehot;
  end

  assign chal_out       = chal_q;
  assign req.resp       = resp_q;
  assign req.busy       = (state_q != ST_IDLE);
  assign req.resp_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer with RESP_BITS=4, VOTES=3, RST=2, SETTLE=3, three modelled rings.
// Ring 1 outputs ~chal_out[0], ring 2 outputs chal_out[0]; ring 0 outputs chal_out[0] or a 1,0,1 vote pattern.
module tb_puf_sequencer;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [2:0]   ring_out;
  logic [2:0]   ring_reset;
  logic [127:0] chal_out;
`ifdef PUF_STABILITY_EN
  logic [15:0]  unstable_cnt;
`endif

  int   n_assert = 0;
  int   n_fail   = 0;
  int   rel_cnt  = 0;
  logic vote_mode;

  puf_sequencer_if #(.SEL_W(2), .CHAL_W(128), .RESP_BITS(4)) req_if ();

  puf_sequencer #(
    .NUM_RINGS(3), .SEL_W(2), .CHAL_W(128), .RESP_BITS(4),
    .VOTES(3), .RST_CYCLES(2), .SETTLE_CYCLES(3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req_if),
    .ring_out   (ring_out),
    .ring_reset (ring_reset),
    .chal_out   (chal_out)
`ifdef PUF_STABILITY_EN
    ,
    .unstable_cnt (unstable_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Count releases of ring 0 so its vote-pattern output is 1,0,1 per bit.
  always @(negedge ring_reset[0]) rel_cnt = rel_cnt + 1;

  always_comb begin
    ring_out[0] = vote_mode ? ((rel_cnt % 3) != 2) : chal_out[0];
    ring_out[1] = ~chal_out[0];
    ring_out[2] = chal_out[0];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] sel, input logic [127:0] chal,
                         output int lat, output logic [2:0] low_seen);
    req_if.ring_sel  = sel;
    req_if.challenge = chal;
    req_if.start     = 1'b1;
    low_seen = 3'b000;
    lat      = 0;
    @(posedge clk); #1;
    req_if.start     = 1'b0;
    req_if.ring_sel  = 2'd0;
    req_if.challenge = '0;
    while (!req_if.resp_valid && lat < 200) begin
      low_seen = low_seen | ~ring_reset;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic accept_resp(input string tag);
    req_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    req_if.resp_ready = 1'b0;
    chk({tag, "_busy"},  128'(req_if.busy), 128'd0);
    chk({tag, "_valid"}, 128'(req_if.resp_valid), 128'd0);
  endtask

  initial begin
    int          lat;
    logic [2:0]  low_seen;
    logic [127:0] seed2;

    reset_n           = 1'b0;
    vote_mode         = 1'b0;
    req_if.start      = 1'b0;
    req_if.abort      = 1'b0;
    req_if.ring_sel   = 2'd0;
    req_if.challenge  = '0;
    req_if.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ring_reset", 128'(ring_reset), 128'h7);
    chk("rst_chal_out",   chal_out, 128'd0);
    chk("rst_resp",       128'(req_if.resp), 128'd0);
    chk("rst_unstable",   128'(req_if.resp_unstable), 128'd0);
    chk("rst_busy",       128'(req_if.busy), 128'd0);
    chk("rst_valid",      128'(req_if.resp_valid), 128'd0);
`ifdef PUF_STABILITY_EN
    chk("rst_ucnt",       128'(unstable_cnt), 128'd0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Ring 1, seed 1: chal[0] per bit 1,0,0,0 -> ring bits 0,1,1,1.
    run_req(2'd1, 128'd1, lat, low_seen);
    chk("r1_latency",  128'(lat), 128'd72);
    chk("r1_resp",     128'(req_if.resp), 128'h7);
    chk("r1_rings",    128'(low_seen), 128'h2);
    chk("r1_chal_end", chal_out, 128'h10);
    chk("r1_unstable", 128'(req_if.resp_unstable), 128'd0);
    accept_resp("r1_acc");

    // Clamped select, seed with bit127 set: chal 1->3->6->12->24, chal[0] 1,1,0,0.
    seed2 = '0;
    seed2[127] = 1'b1;
    seed2[0]   = 1'b1;
    run_req(2'd3, seed2, lat, low_seen);
    chk("r2_latency",  128'(lat), 128'd72);
    chk("r2_resp",     128'(req_if.resp), 128'hC);
    chk("r2_rings",    128'(low_seen), 128'h4);
    chk("r2_chal_end", chal_out, 128'h18);
    accept_resp("r2_acc");

    // Ring 0 votes 1,0,1 every bit -> majority 1, every bit non-unanimous.
    vote_mode = 1'b1;
    run_req(2'd0, 128'd1, lat, low_seen);
    chk("v_latency", 128'(lat), 128'd72);
    chk("v_resp",    128'(req_if.resp), 128'hF);
    chk("v_rings",   128'(low_seen), 128'h1);
`ifdef PUF_STABILITY_EN
    chk("v_unstable", 128'(req_if.resp_unstable), 128'hF);
    chk("v_ucnt",     128'(unstable_cnt), 128'd4);
`else
    chk("v_unstable", 128'(req_if.resp_unstable), 128'd0);
`endif
    accept_resp("v_acc");
    vote_mode = 1'b0;

    // abort together with start in IDLE: request dropped.
    req_if.start = 1'b1;
    req_if.abort = 1'b1;
    req_if.ring_sel = 2'd1;
    @(posedge clk); #1;
    req_if.start = 1'b0;
    req_if.abort = 1'b0;
    chk("abst_busy", 128'(req_if.busy), 128'd0);

    // Abort in SETTLE of bit 2 (edge k+38 enters it).
    req_if.ring_sel  = 2'd1;
    req_if.challenge = 128'd1;
    req_if.start     = 1'b1;
    @(posedge clk); #1;
    req_if.start = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    chk("ab_settle_rings", 128'(ring_reset), 128'h5);
    req_if.abort = 1'b1;
    @(posedge clk); #1;
    req_if.abort = 1'b0;
    chk("ab_busy",    128'(req_if.busy), 128'd0);
    chk("ab_rings",   128'(ring_reset), 128'h7);
    chk("ab_valid",   128'(req_if.resp_valid), 128'd0);
    chk("ab_partial", 128'(req_if.resp), 128'hD);
    chk("ab_chal",    chal_out, 128'h4);
    repeat (5) begin
      @(posedge clk); #1;
      chk("ab_valid_hold", 128'(req_if.resp_valid), 128'd0);
    end
    run_req(2'd1, 128'd1, lat, low_seen);
    chk("ab_re_latency", 128'(lat), 128'd72);
    chk("ab_re_resp",    128'(req_if.resp), 128'h7);

    // DONE with resp_ready low for 10 cycles, start pulses ignored.
    for (int i = 0; i < 10; i++) begin
      req_if.start    = (i % 2 == 0);
      req_if.ring_sel = 2'd2;
      @(posedge clk); #1;
      chk("hold_valid", 128'(req_if.resp_valid), 128'd1);
      chk("hold_resp",  128'(req_if.resp), 128'h7);
    end
    req_if.start = 1'b0;
    accept_resp("hold_acc");
    chk("idle_resp_kept", 128'(req_if.resp), 128'h7);

    // reset_n pulled low in the first SAMPLE (edge k+5).
    req_if.ring_sel  = 2'd1;
    req_if.challenge = 128'd1;
    req_if.start     = 1'b1;
    @(posedge clk); #1;
    req_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mr_sample_rings", 128'(ring_reset), 128'h5);
    chk("mr_sample_busy",  128'(req_if.busy), 128'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_rings",    128'(ring_reset), 128'h7);
    chk("mr_busy",     128'(req_if.busy), 128'd0);
    chk("mr_valid",    128'(req_if.resp_valid), 128'd0);
    chk("mr_resp",     128'(req_if.resp), 128'd0);
    chk("mr_chal",     chal_out, 128'd0);
    chk("mr_unstable", 128'(req_if.resp_unstable), 128'd0);
`ifdef PUF_STABILITY_EN
    chk("mr_ucnt",     128'(unstable_cnt), 128'd0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
